// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory signal bundle for program_loader.
// A byte moves only on a rising edge where rx_valid_i and rx_ready_o are both 1; the sender holds rx_data_i stable while rx_valid_i is high.
interface program_loader_if #(
   parameter int ADDR_W = 10
) ();
   logic              start_i;
   logic [7:0]        rx_data_i;
   logic              rx_valid_i;
   logic              rx_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [15:0]       mem_wdata_o;
   logic              cpu_reset_o;
   logic              busy_o;
   logic              done_o;
   logic              error_o;

   modport slave (
      input  start_i, rx_data_i, rx_valid_i,
      output rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             cpu_reset_o, busy_o, done_o, error_o
   );

   modport master (
      output start_i, rx_data_i, rx_valid_i,
      input  rx_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
             cpu_reset_o, busy_o, done_o, error_o
   );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed 16-bit program image from a byte stream into instruction
// memory and holds the CPU in reset until a load finishes successfully.
module program_loader #(
   parameter int ADDR_W = 10
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   program_loader_if.slave bus,
   output logic [2:0]   state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERR
   } state_e;

   // Largest legal word count is the full memory depth.
   localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

   state_e            state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [7:0]        data_hi_q, data_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       remaining_q, remaining_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              rx_ready;
   logic              accept;
   logic [15:0]       len_w;

   always_comb begin
      rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
   end

   assign accept = bus.rx_valid_i && rx_ready;
   assign len_w  = {len_hi_q, bus.rx_data_i};

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      data_hi_d   = data_hi_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start_i) state_d = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               len_hi_d = bus.rx_data_i;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               if ((len_w == 16'd0) || ({1'b0, len_w} > MAX_LEN)) begin
                  state_d = S_ERR;
               end else begin
                  addr_d      = '0;
                  remaining_d = len_w;
                  state_d     = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               data_hi_d = bus.rx_data_i;
               state_d   = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            // The write port is loaded here so it is stable for the whole WRITE cycle
            // and otherwise keeps showing the last word written.
            if (accept) begin
               mem_addr_d  = addr_q;
               mem_wdata_d = {data_hi_q, bus.rx_data_i};
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            if (remaining_q == 16'd1) begin
               state_d = S_DONE;
            end else begin
               addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               remaining_d = remaining_q - 16'd1;
               state_d     = S_DATA_HI;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         len_hi_q    <= '0;
         data_hi_q   <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         data_hi_q   <= data_hi_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.rx_ready_o  = rx_ready;
   assign bus.mem_we_o    = (state_q == S_WRITE);
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.busy_o      = rx_ready || (state_q == S_WRITE);
   assign bus.done_o      = (state_q == S_DONE);
   assign bus.error_o     = (state_q == S_ERR);
   assign bus.cpu_reset_o = (state_q != S_DONE);
   assign state_o         = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte-stream driver, write monitor and an
// expected-write queue built from the image contents.
module tb_program_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0] state;
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [ADDR_W+15:0] exp_q[$];
   logic [ADDR_W+15:0] obs_q[$];
   int                 obs_cyc[$];
   logic [7:0]         bytes_q[$];

   program_loader_if #(.ADDR_W(ADDR_W)) bus();

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .state_o(state)
   );

   // ---------------- clock / reset / monitor ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.mem_we_o === 1'b1) begin
         obs_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});
         obs_cyc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
   endtask

   // Reference model: stream bytes and the writes a correct loader must perform.
   task automatic build_image(input int len, input int nwords);
      logic [15:0] w;
      logic [15:0] l;
      l = 16'(len);
      bytes_q.delete();
      exp_q.delete();
      bytes_q.push_back(l[15:8]);
      bytes_q.push_back(l[7:0]);
      for (int i = 0; i < nwords; i++) begin
         w = 16'($urandom);
         bytes_q.push_back(w[15:8]);
         bytes_q.push_back(w[7:0]);
         if (len >= 1 && len <= DEPTH && i < len) exp_q.push_back({ADDR_W'(i), w});
      end
   endtask

   task automatic send_bytes(input int n, input int gap_max);
      for (int i = 0; i < n; i++) begin
         int gaps;
         int waited;
         logic [7:0] b;
         if (bytes_q.size() == 0) break;
         gaps = int'($urandom_range(gap_max, 0));
         waited = 0;
         b = bytes_q.pop_front();
         if (gaps > 0) begin
            bus.rx_valid_i = 1'b0;
            repeat (gaps) @(posedge clk);
            #1;
         end
         bus.rx_valid_i = 1'b1;
         bus.rx_data_i  = b;
         forever begin
            @(negedge clk);
            if (bus.rx_ready_o === 1'b1) break;
            waited++;
            if (waited > 20) begin
               vectors++; miscompares++;
               $display("FAIL rx_accept_timeout: rx_ready=%b after %0d cycles, expected 1", bus.rx_ready_o, waited);
               break;
            end
         end
         @(posedge clk);
         #1;
      end
      bus.rx_valid_i = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.start_i = 1'b0; bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++; if (bus.mem_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we_o); end
      vectors++; if (bus.mem_addr_o !== '0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr_o); end
      vectors++; if (bus.mem_wdata_o !== 16'h0) begin miscompares++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata_o); end
      vectors++; if (bus.rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_rx_ready: got %b expected 0", bus.rx_ready_o); end
      vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
      vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
      vectors++; if (bus.error_o !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", bus.error_o); end
      vectors++; if (bus.cpu_reset_o !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset: got %b expected 1", bus.cpu_reset_o); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      vectors++; if (bus.busy_o !== 1'b0 || bus.rx_ready_o !== 1'b0) begin miscompares++; $display("FAIL idle_hold: busy=%b rx_ready=%b expected 0 0", bus.busy_o, bus.rx_ready_o); end
   endtask

   task automatic test_basic();
      obs_q.delete(); obs_cyc.delete();
      bytes_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      exp_q   = '{{10'd0, 16'h1234}, {10'd1, 16'hABCD}};
      pulse_start();
      send_bytes(6, 0);
      @(negedge clk);
      vectors++; if (bus.mem_we_o !== 1'b1) begin miscompares++; $display("FAIL basic_last_we: got %b expected 1", bus.mem_we_o); end
      @(negedge clk);
      vectors++; if (bus.done_o !== 1'b1 || bus.cpu_reset_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         miscompares++; $display("FAIL basic_done: done=%b cpu_reset=%b busy=%b expected 1 0 0", bus.done_o, bus.cpu_reset_o, bus.busy_o);
      end
      @(posedge clk); #1;
      vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      if (obs_cyc.size() == 2) begin
         vectors++; if (obs_cyc[1] - obs_cyc[0] != 3) begin miscompares++; $display("FAIL basic_spacing: got %0d cycles expected 3", obs_cyc[1] - obs_cyc[0]); end
      end
   endtask

   task automatic test_len_zero();
      obs_q.delete();
      pulse_start();
      build_image(0, 0);
      send_bytes(2, 0);
      @(negedge clk);
      vectors++; if (bus.error_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.cpu_reset_o !== 1'b1) begin
         miscompares++; $display("FAIL len0_err: error=%b busy=%b cpu_reset=%b expected 1 0 1", bus.error_o, bus.busy_o, bus.cpu_reset_o);
      end
      @(posedge clk); #1;
      pulse_start();
      @(negedge clk);
      vectors++; if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.rx_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL len0_restart: error=%b busy=%b rx_ready=%b expected 0 1 1", bus.error_o, bus.busy_o, bus.rx_ready_o);
      end
      @(posedge clk); #1;
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL len0_nowrite: got %0d writes expected 0", obs_q.size()); end
   endtask

   // Entered with the loader already in LEN_HI.
   task automatic test_len_boundary();
      obs_q.delete();
      build_image(16'h0401, 0);
      send_bytes(2, 0);
      @(negedge clk);
      vectors++; if (bus.error_o !== 1'b1 || obs_q.size() != 0) begin
         miscompares++; $display("FAIL len401_err: error=%b writes=%0d expected 1 0", bus.error_o, obs_q.size());
      end
      @(posedge clk); #1;
      pulse_start();
      build_image(DEPTH, DEPTH);
      send_bytes(bytes_q.size(), 0);
      @(negedge clk);
      vectors++; if (bus.mem_we_o !== 1'b1) begin miscompares++; $display("FAIL len400_last_we: got %b expected 1", bus.mem_we_o); end
      @(negedge clk);
      vectors++; if (bus.done_o !== 1'b1 || bus.error_o !== 1'b0) begin miscompares++; $display("FAIL len400_done: done=%b error=%b expected 1 0", bus.done_o, bus.error_o); end
      @(posedge clk); #1;
      vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL len400_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL len400_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      if (obs_q.size() > 0) begin
         vectors++; if (obs_q[obs_q.size()-1][ADDR_W+15:16] !== 10'h3FF) begin
            miscompares++; $display("FAIL len400_last_addr: got %h expected 3ff", obs_q[obs_q.size()-1][ADDR_W+15:16]);
         end
      end
   endtask

   task automatic test_gaps();
      for (int r = 0; r < 4; r++) begin
         int len;
         len = (r == 0) ? 3 : int'($urandom_range(8, 1));
         obs_q.delete();
         pulse_start();
         build_image(len, len);
         send_bytes(bytes_q.size(), 3);
         @(negedge clk);
         vectors++; if (bus.mem_we_o !== 1'b1) begin miscompares++; $display("FAIL gaps_last_we[%0d]: got %b expected 1", r, bus.mem_we_o); end
         @(negedge clk);
         vectors++; if (bus.done_o !== 1'b1) begin miscompares++; $display("FAIL gaps_done[%0d]: got %b expected 1", r, bus.done_o); end
         @(posedge clk); #1;
         vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL gaps_count[%0d]: got %0d writes expected %0d", r, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL gaps_write[%0d][%0d]: got %h expected %h", r, i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_start_busy();
      obs_q.delete();
      pulse_start();
      build_image(2, 2);
      send_bytes(3, 0);
      pulse_start();
      @(negedge clk);
      vectors++; if (bus.busy_o !== 1'b1 || bus.rx_ready_o !== 1'b1) begin
         miscompares++; $display("FAIL busy_start_ignored: busy=%b rx_ready=%b expected 1 1", bus.busy_o, bus.rx_ready_o);
      end
      @(posedge clk); #1;
      send_bytes(3, 0);
      idle(3);
      vectors++; if (bus.done_o !== 1'b1) begin miscompares++; $display("FAIL busy_done: got %b expected 1", bus.done_o); end
      vectors++; if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL busy_count: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         vectors++; if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL busy_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete();
      pulse_start();
      @(negedge clk);
      vectors++; if (bus.cpu_reset_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
         miscompares++; $display("FAIL done_restart: cpu_reset=%b busy=%b done=%b expected 1 1 0", bus.cpu_reset_o, bus.busy_o, bus.done_o);
      end
      @(posedge clk); #1;
      build_image(1, 1);
      send_bytes(bytes_q.size(), 0);
      idle(2);
      vectors++; if (obs_q.size() != 1 || obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL reload_count: got %0d writes expected 1", obs_q.size()); end
      else begin
         vectors++; if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL reload_write: got %h expected %h", obs_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_reset_mid();
      obs_q.delete();
      pulse_start();
      build_image(2, 2);
      send_bytes(5, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++; if (bus.busy_o !== 1'b0 || bus.rx_ready_o !== 1'b0 || bus.cpu_reset_o !== 1'b1 || bus.mem_we_o !== 1'b0) begin
         miscompares++; $display("FAIL midreset_idle: busy=%b rx_ready=%b cpu_reset=%b mem_we=%b expected 0 0 1 0",
                                 bus.busy_o, bus.rx_ready_o, bus.cpu_reset_o, bus.mem_we_o);
      end
      vectors++; if (bus.mem_addr_o !== '0 || bus.mem_wdata_o !== 16'h0) begin
         miscompares++; $display("FAIL midreset_port: addr=%h wdata=%h expected 0 0", bus.mem_addr_o, bus.mem_wdata_o);
      end
      @(posedge clk); #1;
      idle(5);
      exp_q.pop_back();
      vectors++; if (obs_q.size() != 1) begin miscompares++; $display("FAIL midreset_count: got %0d writes expected 1", obs_q.size()); end
      else begin
         vectors++; if (obs_q[0] !== exp_q[0]) begin miscompares++; $display("FAIL midreset_word0: got %h expected %h", obs_q[0], exp_q[0]); end
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i = 8'h00;
      test_reset();
      test_basic();
      test_len_zero();
      test_len_boundary();
      test_gaps();
      test_start_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, instruction memory address width (1K x 16 words).
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset).
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 rx_data  input  8  incoming program byte.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  instruction memory write enable.
REQ-009 mem_addr  output  ADDR_W  instruction memory write address.
REQ-010 mem_wdata  output  16  instruction word to write.
REQ-011 cpu_reset  output  1  active-high hold-in-reset for the CPU.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted on an illegal length.

Function
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-016 A byte is accepted on a cycle with rx_valid=1 and rx_ready=1; no other byte is consumed.
REQ-017 rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-018 IDLE, DONE, ERR: start=1 -> LEN_HI next cycle; otherwise the state holds.
REQ-019 start is ignored in LEN_HI, LEN_LO, DATA_HI, DATA_LO and WRITE.
REQ-020 Stream format: 16-bit word count, high byte first, then count words, each high byte first.
REQ-021 LEN_HI on accept -> LEN_LO; LEN_LO on accept latches len={hi,lo}.
REQ-022 On the LEN_LO accept: len=0 or len>2^ADDR_W -> ERR; otherwise -> DATA_HI, with write address cleared to 0 and remaining count set to len.
REQ-023 DATA_HI on accept latches the high byte -> DATA_LO; DATA_LO on accept latches the low byte -> WRITE.
REQ-024 WRITE lasts exactly one cycle: mem_we=1, mem_addr=current address, mem_wdata={high,low}.
REQ-025 After WRITE: remaining=1 -> DONE; otherwise address+1 and remaining-1 -> DATA_HI.
REQ-026 mem_we=0 in every state except WRITE; mem_addr and mem_wdata hold their last values when mem_we=0.
REQ-027 Minimum throughput is 3 cycles per word with rx_valid held at 1; idle rx_valid cycles stall the FSM without side effects.
REQ-028 Address never wraps: the largest legal len writes the last address 2^ADDR_W-1, then goes to DONE.
REQ-029 busy=1 in LEN_HI through WRITE; done=1 only in DONE; error=1 only in ERR.
REQ-030 cpu_reset=0 only in DONE; it is 1 in all other states, including ERR.
REQ-031 Outputs are registered or decoded from the state register only; no combinational path from rx_valid or start to any output.

Reset
REQ-032 reset=0 on a rising edge forces IDLE and sets: mem_we=0, mem_addr=0, mem_wdata=0, rx_ready=0, busy=0, done=0, error=0, cpu_reset=1.
REQ-033 Reset takes priority over start, rx_valid and every state transition.
REQ-034 Reset mid-load discards any partial word and suppresses any pending write; memory contents already written are not modified.

Verification
REQ-035 Release reset; start; len 0x0002; bytes 12 34 AB CD back-to-back -> writes addr0=0x1234 then addr1=0xABCD, 3 cycles apart; done=1 and cpu_reset=0 the cycle after the second write.
REQ-036 start; len 0x0000 -> error=1, busy=0, cpu_reset=1, no mem_we; a following start clears error and enters LEN_HI.
REQ-037 Length boundaries: len 0x0401 -> ERR with no write; len 0x0400 -> 1024 writes, last at addr 0x3FF, then DONE.
REQ-038 Random rx_valid gaps during len 0x0003 -> rx_ready and the writes pause during gaps; written addresses and data identical to the gap-free run.
REQ-039 reset=0 asserted in DATA_LO after the high byte of word 1 -> IDLE next cycle, no mem_we for word 1, word 0 intact, cpu_reset=1.
REQ-040 start pulsed while busy -> ignored; start pulsed in DONE -> cpu_reset=1 and state LEN_HI on the next cycle, new image overwrites from addr 0.
